// File: rtl/ahb3lite_mem_slave.sv
// AHB3-Lite single-port memory slave with configurable wait states.
// Optional feature: define AHB_MEM_ERR_RESP_EN to answer invalid transfers
// (out of range, oversize or misaligned) with a two-cycle ERROR response.
// Without it, invalid transfers complete OKAY; writes are dropped and reads return 0.
//
// state   | meaning
// DP_IDLE | no data phase in progress, HREADYOUT high
// DP_WAIT | inserted wait cycles, HREADYOUT low
// DP_LAST | final data-phase cycle: write commit / read data driven
// DP_ERR1 | first ERROR cycle, HREADYOUT low
// DP_ERR2 | second ERROR cycle, HREADYOUT high
module ahb3lite_mem_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int IDXW = ADDR_WIDTH - OFFW;
  localparam int MEMW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

`ifdef AHB_MEM_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    DP_IDLE,
    DP_WAIT,
    DP_LAST,
    DP_ERR1,
    DP_ERR2
  } dp_state_t;

  dp_state_t state, state_nxt;
  logic [2:0] wait_cnt, wait_cnt_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // data-phase copy of the accepted address phase
  logic [MEMW-1:0]       dp_idx;
  logic [NB-1:0]         dp_mask;
  logic                  dp_write;
  logic                  dp_ok;
  logic [DATA_WIDTH-1:0] rd_buf;

  // address-phase decode
  logic [IDXW-1:0]       a_idx;
  logic [OFFW-1:0]       a_off;
  logic [MEMW-1:0]       a_mem_idx;
  logic                  a_in_range;
  logic                  a_size_ok;
  logic                  a_aligned;
  logic                  a_valid;
  logic [NB-1:0]         a_mask;
  logic                  accept;
  logic                  commit;
  logic [DATA_WIDTH-1:0] fwd_word;

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

  assign a_idx      = HADDR[ADDR_WIDTH-1:OFFW];
  assign a_off      = HADDR[OFFW-1:0];
  assign a_mem_idx  = MEMW'(a_idx);
  assign a_in_range = (32'(a_idx) < 32'(DEPTH));
  assign a_size_ok  = (32'(HSIZE) <= 32'(OFFW));
  assign a_aligned  = ((32'(a_off) & ((32'd1 << HSIZE) - 32'd1)) == 32'd0);
  assign a_valid    = a_in_range & a_size_ok & a_aligned;

  // little-endian byte lanes covered by the transfer
  always_comb begin
    a_mask = '0;
    for (int b = 0; b < NB; b++) begin
      a_mask[b] = (32'(b) >= 32'(a_off)) && (32'(b) < 32'(a_off) + (32'd1 << HSIZE));
    end
  end

  // address phases are only taken when no data phase is stalling the bus
  assign accept = HSEL & HREADY & HTRANS[1] &
                  ((state == DP_IDLE) | (state == DP_LAST) | (state == DP_ERR2));

  // a reset edge that lands on DP_LAST discards the pending write
  assign commit = (state == DP_LAST) & dp_write & dp_ok & ~HRESET;

  // read word with lanes from a write committing this same cycle merged in
  always_comb begin
    fwd_word = mem[a_mem_idx];
    for (int b = 0; b < NB; b++) begin
      if (commit && (dp_idx == a_mem_idx) && dp_mask[b]) begin
        fwd_word[b*8 +: 8] = HWDATA[b*8 +: 8];
      end
    end
  end

  // next-state and wait-counter logic
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      DP_WAIT: begin
        if (wait_cnt == 3'd0) begin
          state_nxt = DP_LAST;
        end else begin
          wait_cnt_nxt = wait_cnt - 3'd1;
        end
      end
      DP_ERR1: state_nxt = DP_ERR2;
      default: begin
        state_nxt = DP_IDLE;
        if (accept) begin
          if (!a_valid && ERR_EN) begin
            state_nxt = DP_ERR1;
          end else if (HAS_WAIT) begin
            state_nxt    = DP_WAIT;
            wait_cnt_nxt = WS_LOAD;
          end else begin
            state_nxt = DP_LAST;
          end
        end
      end
    endcase
  end

  // FSM state and wait counter registers
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= DP_IDLE;
      wait_cnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // register address-phase controls and snapshot read data for the data phase
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_write <= 1'b0;
      dp_ok    <= 1'b0;
      rd_buf   <= '0;
    end else if (accept) begin
      dp_idx   <= a_mem_idx;
      dp_mask  <= a_mask;
      dp_write <= HWRITE;
      dp_ok    <= a_valid;
      if (!HWRITE && a_valid) begin
        rd_buf <= fwd_word;
      end
    end
  end

  // byte-lane write commit at the end of DP_LAST; contents survive reset
  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int b = 0; b < NB; b++) begin
        if (dp_mask[b]) begin
          mem[dp_idx][b*8 +: 8] <= HWDATA[b*8 +: 8];
        end
      end
    end
  end

  assign HREADYOUT = !((state == DP_WAIT) || (state == DP_ERR1));
  assign HRESP     = (state == DP_ERR1) || (state == DP_ERR2);
  assign HRDATA    = ((state == DP_LAST) && !dp_write && dp_ok) ? rd_buf : '0;

endmodule

// File: tb/tb_ahb3lite_mem_slave.sv
// Scoreboard bench for ahb3lite_mem_slave: three instances with 0, 2 and 3
// wait states. The driver queues the expected data-phase result for every
// selected address phase; the monitor checks each data phase as it completes.
module tb_ahb3lite_mem_slave;

  localparam int NU = 3;

  logic        clk;
  logic        hreset   [NU];
  logic        hsel     [NU];
  logic        hwrite   [NU];
  logic [1:0]  htrans   [NU];
  logic [2:0]  hsize    [NU];
  logic [15:0] haddr    [NU];
  logic [31:0] hwdata   [NU];
  logic        hreadyout[NU];
  logic        hresp    [NU];
  logic [31:0] hrdata   [NU];
  logic [2:0]  hburst;
  logic [3:0]  hprot;

  int ws [NU] = '{0, 2, 3};

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] mask;
    logic        resp;
    logic [3:0]  waits;
  } exp_t;

  exp_t  sbq[$];
  string nameq[$];
  int    checks = 0;
  int    errors = 0;

  ahb3lite_mem_slave #(.WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESET(hreset[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HWRITE(hwrite[0]),
    .HTRANS(htrans[0]), .HSIZE(hsize[0]), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata[0]),
    .HREADY(hreadyout[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]));

  ahb3lite_mem_slave #(.WAIT_STATES(2)) u_dut1 (
    .HCLK(clk), .HRESET(hreset[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HWRITE(hwrite[1]),
    .HTRANS(htrans[1]), .HSIZE(hsize[1]), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata[1]),
    .HREADY(hreadyout[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]));

  ahb3lite_mem_slave #(.WAIT_STATES(3)) u_dut2 (
    .HCLK(clk), .HRESET(hreset[2]), .HSEL(hsel[2]), .HADDR(haddr[2]), .HWRITE(hwrite[2]),
    .HTRANS(htrans[2]), .HSIZE(hsize[2]), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata[2]),
    .HREADY(hreadyout[2]), .HREADYOUT(hreadyout[2]), .HRESP(hresp[2]), .HRDATA(hrdata[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  // monitor: outputs are stable at the falling edge
  initial begin
    bit   active [NU];
    int   waits  [NU];
    exp_t e;
    string nm;
    for (int u = 0; u < NU; u++) begin
      active[u] = 1'b0;
      waits[u]  = 0;
    end
    forever begin
      @(negedge clk);
      for (int u = 0; u < NU; u++) begin
        if (hreset[u]) begin
          active[u] = 1'b0;
          continue;
        end
        if (active[u]) begin
          if (sbq.size() == 0) begin
            check("unexpected_data_phase", 32'd1, 32'd0);
            active[u] = 1'b0;
          end else if (!hreadyout[u]) begin
            waits[u]++;
            check({nameq[0], "_wait_resp"}, 32'(hresp[u]), 32'(sbq[0].resp));
            check({nameq[0], "_wait_rdata"}, hrdata[u], 32'd0);
          end else begin
            e  = sbq.pop_front();
            nm = nameq.pop_front();
            check({nm, "_resp"}, 32'(hresp[u]), 32'(e.resp));
            check({nm, "_waits"}, 32'(waits[u]), 32'(e.waits));
            check({nm, "_rdata"}, hrdata[u] & e.mask, e.data & e.mask);
            active[u] = 1'b0;
          end
        end
        if (hsel[u] && hreadyout[u]) begin
          active[u] = 1'b1;
          waits[u]  = 0;
        end
      end
    end
  end

  // one address phase; expectation is queued before the accepting edge
  task automatic xfer(input int u, input logic [1:0] trans, input logic wr, input logic [15:0] addr,
                      input logic [2:0] size, input logic [31:0] wdata, input string name,
                      input logic [31:0] edata, input logic [31:0] emask, input logic eresp,
                      input int ewaits);
    int guard = 0;
    hsel[u]   = 1'b1;
    htrans[u] = trans;
    hwrite[u] = wr;
    haddr[u]  = addr;
    hsize[u]  = size;
    while (!hreadyout[u] && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) check({name, "_ready_timeout"}, 32'd0, 32'd1);
    sbq.push_back('{data: edata, mask: emask, resp: eresp, waits: 4'(ewaits)});
    nameq.push_back(name);
    @(posedge clk); #1;
    if (wr) hwdata[u] = wdata;
  endtask

  task automatic wr(input int u, input logic [15:0] addr, input logic [2:0] size,
                    input logic [31:0] wdata, input string name);
    xfer(u, 2'b10, 1'b1, addr, size, wdata, name, 32'd0, 32'd0, 1'b0, ws[u]);
  endtask

  task automatic rd(input int u, input logic [15:0] addr, input logic [2:0] size,
                    input logic [31:0] edata, input string name);
    xfer(u, 2'b10, 1'b0, addr, size, 32'd0, name, edata, 32'hFFFF_FFFF, 1'b0, ws[u]);
  endtask

  task automatic bad(input int u, input logic wrn, input logic [15:0] addr, input logic [2:0] size,
                     input string name);
`ifdef AHB_MEM_ERR_RESP_EN
    xfer(u, 2'b10, wrn, addr, size, 32'hA5A5_A5A5, name, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
`else
    xfer(u, 2'b10, wrn, addr, size, 32'hA5A5_A5A5, name, 32'd0, 32'hFFFF_FFFF, 1'b0, ws[u]);
`endif
  endtask

  task automatic idle_bus(input int u);
    int guard = 0;
    hsel[u]   = 1'b0;
    htrans[u] = 2'b00;
    hwrite[u] = 1'b0;
    while (sbq.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) begin
      check("drain_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
      nameq.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int guard;
    hburst = 3'b001;
    hprot  = 4'b0011;
    for (int u = 0; u < NU; u++) begin
      hreset[u] = 1'b1;
      hsel[u]   = 1'b0;
      hwrite[u] = 1'b0;
      htrans[u] = 2'b00;
      hsize[u]  = 3'd0;
      haddr[u]  = 16'd0;
      hwdata[u] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < NU; u++) hreset[u] = 1'b0;
    for (int u = 0; u < NU; u++) begin
      check($sformatf("reset_ready%0d", u), 32'(hreadyout[u]), 32'd1);
      check($sformatf("reset_resp%0d", u), 32'(hresp[u]), 32'd0);
      check($sformatf("reset_rdata%0d", u), hrdata[u], 32'd0);
    end

    // byte burst with a BUSY in the middle, then word read (forwarded from last byte)
    xfer(0, 2'b10, 1'b1, 16'h0020, 3'd0, {4{8'hDE}}, "wb20", 32'd0, 32'd0, 1'b0, 0);
    xfer(0, 2'b01, 1'b1, 16'h0021, 3'd0, 32'hFFFF_FFFF, "busy", 32'd0, 32'hFFFF_FFFF, 1'b0, 0);
    xfer(0, 2'b11, 1'b1, 16'h0021, 3'd0, {4{8'hAD}}, "wb21", 32'd0, 32'd0, 1'b0, 0);
    xfer(0, 2'b11, 1'b1, 16'h0022, 3'd0, {4{8'hBE}}, "wb22", 32'd0, 32'd0, 1'b0, 0);
    xfer(0, 2'b11, 1'b1, 16'h0023, 3'd0, {4{8'hEF}}, "wb23", 32'd0, 32'd0, 1'b0, 0);
    rd(0, 16'h0020, 3'd2, 32'hEFBE_ADDE, "rd20");
    idle_bus(0);

    // IDLE with write attributes must not touch memory
    xfer(0, 2'b00, 1'b1, 16'h0020, 3'd2, 32'hFFFF_FFFF, "idle_wr", 32'd0, 32'hFFFF_FFFF, 1'b0, 0);
    rd(0, 16'h0020, 3'd2, 32'hEFBE_ADDE, "rd20_after_idle");
    idle_bus(0);

    // write then immediate read, half and byte lane merges
    wr(0, 16'h0040, 3'd2, 32'h1234_5678, "ww40");
    rd(0, 16'h0040, 3'd2, 32'h1234_5678, "rd40_fwd");
    wr(0, 16'h0042, 3'd1, {2{16'hBEEF}}, "wh42");
    wr(0, 16'h0041, 3'd0, {4{8'h99}}, "wb41");
    idle_bus(0);
    rd(0, 16'h0040, 3'd2, 32'hBEEF_9978, "rd40_lanes");
    idle_bus(0);

    // invalid transfers: range, misalignment, oversize
    wr(0, 16'h0000, 3'd2, 32'h0BAD_CAFE, "ww00");
    bad(0, 1'b1, 16'h1000, 3'd2, "bad_wr_range");
    rd(0, 16'h0000, 3'd2, 32'h0BAD_CAFE, "rd00_no_alias");
    bad(0, 1'b0, 16'h1000, 3'd2, "bad_rd_range");
    bad(0, 1'b0, 16'h0022, 3'd2, "bad_rd_misalign");
    bad(0, 1'b1, 16'h0041, 3'd1, "bad_wr_misalign");
    bad(0, 1'b0, 16'h0040, 3'd3, "bad_rd_dword");
    rd(0, 16'h0040, 3'd2, 32'hBEEF_9978, "rd40_unchanged");
    wr(0, 16'h0FFC, 3'd2, 32'h5A5A_0FFC, "ww_last");
    rd(0, 16'h0FFC, 3'd2, 32'h5A5A_0FFC, "rd_last");
    idle_bus(0);

    // two wait states
    wr(1, 16'h0020, 3'd2, 32'hEFBE_ADDE, "ws2_ww20");
    idle_bus(1);
    rd(1, 16'h0020, 3'd2, 32'hEFBE_ADDE, "ws2_rd20");
    bad(1, 1'b0, 16'h1000, 3'd2, "ws2_bad_rd");
    idle_bus(1);

    // three wait states, reset in the second wait cycle of a write
    wr(2, 16'h0080, 3'd2, 32'h1122_3344, "ws3_pre");
    idle_bus(2);
    hsel[2]   = 1'b1;
    htrans[2] = 2'b10;
    hwrite[2] = 1'b1;
    haddr[2]  = 16'h0080;
    hsize[2]  = 3'd2;
    guard = 0;
    while (!hreadyout[2] && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) check("abort_ready_timeout", 32'd0, 32'd1);
    sbq.push_back('{data: 32'd0, mask: 32'd0, resp: 1'b0, waits: 4'd3});
    nameq.push_back("ws3_aborted");
    @(posedge clk); #1;
    hwdata[2] = 32'hCAFE_F00D;
    hsel[2]   = 1'b0;
    htrans[2] = 2'b00;
    hwrite[2] = 1'b0;
    check("abort_in_wait1", 32'(hreadyout[2]), 32'd0);
    @(posedge clk); #1;
    check("abort_in_wait2", 32'(hreadyout[2]), 32'd0);
    hreset[2] = 1'b1;
    @(posedge clk); #1;
    hreset[2] = 1'b0;
    check("abort_ready", 32'(hreadyout[2]), 32'd1);
    check("abort_resp", 32'(hresp[2]), 32'd0);
    check("abort_rdata", hrdata[2], 32'd0);
    sbq.delete();
    nameq.delete();
    rd(2, 16'h0080, 3'd2, 32'h1122_3344, "ws3_rd80");
    idle_bus(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ahb3lite_mem_slave.md
AHB3LITE_MEM_SLAVE -- requirements
Module: ahb3lite_mem_slave

Interface
REQ-001 Parameter DATA_WIDTH, default 32, bus width in bits (legal 32 or 64).
REQ-002 Parameter ADDR_WIDTH, default 16, HADDR width in bits, byte address.
REQ-003 Parameter DEPTH, default 1024, memory size in DATA_WIDTH-bit words.
REQ-004 Parameter WAIT_STATES, default 0, inserted wait cycles per data phase (legal 0..7).
REQ-005 HCLK  input  1  single clock; all logic on rising edge.
REQ-006 HRESET  input  1  reset, synchronous, active-high.
REQ-007 HSEL  input  1  slave select.
REQ-008 HADDR  input  ADDR_WIDTH  byte address.
REQ-009 HWRITE  input  1  1=write, 0=read.
REQ-010 HTRANS  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-011 HSIZE  input  3  transfer size, 0=byte, 1=half, 2=word, 3=dword.
REQ-012 HBURST  input  3  burst type; accepted, no functional effect.
REQ-013 HPROT  input  4  protection; accepted, no functional effect.
REQ-014 HWDATA  input  DATA_WIDTH  write data, data phase.
REQ-015 HREADY  input  1  bus-level ready; address phase sampled only when high.
REQ-016 HREADYOUT  output  1  slave ready.
REQ-017 HRESP  output  1  0=OKAY, 1=ERROR.
REQ-018 HRDATA  output  DATA_WIDTH  read data, valid in last data-phase cycle.

Function
REQ-019 Transfer accepted when HSEL & HREADY & HTRANS[1] at a rising edge; address, size, direction registered for the data phase.
REQ-020 IDLE or BUSY, or HSEL=0, SHALL cause no memory access and a zero-wait OKAY data phase, regardless of HWRITE/HWDATA.
REQ-021 Data-phase FSM states: DP_IDLE, DP_WAIT, DP_LAST, DP_ERR1, DP_ERR2.
REQ-022 Accepted transfer with WAIT_STATES=N>0: DP_WAIT for N cycles (HREADYOUT=0, HRESP=0), then DP_LAST for 1 cycle (HREADYOUT=1); N=0 goes straight to DP_LAST.
REQ-023 New transfer may be accepted in the DP_LAST cycle (pipelined back-to-back); otherwise return to DP_IDLE.
REQ-024 Word index = HADDR >> log2(DATA_WIDTH/8); byte lanes from HADDR low bits and HSIZE, little-endian.
REQ-025 Write: HWDATA lanes committed to memory at the end of DP_LAST; unselected lanes unchanged.
REQ-026 Read: HRDATA carries the full addressed word in DP_LAST; unselected lanes may be any value; HRDATA=0 outside DP_LAST.
REQ-027 Read whose address phase coincides with DP_LAST of a write to the same word SHALL return merged (forwarded) new write lanes.
REQ-028 Invalid transfer = word index >= DEPTH, or HSIZE > log2(DATA_WIDTH/8), or address misaligned to HSIZE.
REQ-029 BUSY within a burst does not break the burst; following SEQ is accepted normally.

Reset
REQ-030 HRESET high at a rising edge: FSM to DP_IDLE, wait counter 0, pending transfer discarded (no write commit), HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-031 Memory contents are not cleared by reset.
REQ-032 Reset asserted during DP_WAIT or DP_ERR1 aborts the transfer; next cycle is DP_IDLE.

Configuration
REQ-033 Macro AHB_MEM_ERR_RESP_EN defined: invalid transfer enters DP_ERR1 (HREADYOUT=0, HRESP=1) then DP_ERR2 (HREADYOUT=1, HRESP=1), no memory access, no wait states.
REQ-034 Macro undefined: invalid transfer completes with normal wait timing and OKAY; writes discarded, reads return 0.

Verification
REQ-035 Byte writes 0xDE,0xAD,0xBE,0xEF to 0x20..0x23 with a BUSY between first and second, then word read at 0x20 -> HRDATA=0xEFBEADDE, all HRESP=0.
REQ-036 IDLE with HWRITE=1, HADDR=0x20, HWDATA=0xFFFFFFFF, then read 0x20 -> still 0xEFBEADDE; IDLE data phase HREADYOUT=1.
REQ-037 Word write 0x12345678 to 0x40 immediately followed by word read 0x40 -> HRDATA=0x12345678 via forwarding.
REQ-038 WAIT_STATES=2, read 0x20 -> HREADYOUT low exactly 2 cycles, data 0xEFBEADDE in third data-phase cycle.
REQ-039 With AHB_MEM_ERR_RESP_EN, word read at byte address 4*DEPTH -> HRESP=1 two cycles, HREADYOUT 0 then 1; without macro -> OKAY, HRDATA=0.
REQ-040 WAIT_STATES=3, write 0xCAFEF00D to 0x80, HRESET pulsed in second wait cycle -> read 0x80 returns prior contents, HREADYOUT=1 after reset.
